// File: rtl/poly_mul_pkg.sv
// Shared poly_mul constants and the NTT scheduler state encoding.
// Widths here are reused by the coefficient RAM and twiddle ROM.
package poly_mul_pkg;

  localparam int PM_LOG_N        = 3;
  localparam int PM_N            = 1 << PM_LOG_N;
  localparam int PM_HALF_N       = PM_N / 2;
  localparam int PM_ADDR_W       = PM_LOG_N;
  localparam int PM_TW_W         = PM_LOG_N - 1;
  localparam int PM_K_W          = PM_LOG_N - 1;
  localparam int PM_STG_W        = $clog2(PM_LOG_N);
  localparam int PM_MAX_INFLIGHT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_e;

  function automatic int pm_cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Radix-2 DIT butterfly address map: (k, stage) -> a, b, twiddle.
// Purely combinational; the scheduler registers the results.
module ntt_addr_gen
  import poly_mul_pkg::*;
#(
  parameter int LOG_N = PM_LOG_N,
  parameter int STG_W = $clog2(LOG_N)
) (
  input  logic [LOG_N-2:0] k,
  input  logic [STG_W-1:0] stage,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-2:0] tw_addr
);

  localparam logic [LOG_N-1:0] ONE   = LOG_N'(1);
  localparam logic [STG_W-1:0] S_TOP = STG_W'(LOG_N - 1);

  logic [LOG_N-1:0] kx;
  logic [LOG_N-1:0] half;
  logic [LOG_N-1:0] pos;
  logic [LOG_N-1:0] grp;
  logic [LOG_N-1:0] base;

  // Split k into group and in-group position, then spread by 2^(s+1)
  always_comb begin
    kx      = {1'b0, k};
    half    = ONE << stage;
    pos     = kx & (half - ONE);
    grp     = kx >> stage;
    base    = grp << stage;
    addr_a  = (base << 1) | pos;
    addr_b  = addr_a | half;
    tw_addr = pos[LOG_N-2:0] << (S_TOP - stage);
  end

endmodule

// File: rtl/ntt_stage_sched.sv
// In-place radix-2 DIT NTT scheduler: one butterfly command per cycle,
// stages gated on full write-back retirement of the previous stage.
module ntt_stage_sched
  import poly_mul_pkg::*;
#(
  parameter int LOG_N        = PM_LOG_N,
  parameter int MAX_INFLIGHT = PM_MAX_INFLIGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     bf_valid,
  input  logic                     bf_ready,
  output logic [LOG_N-1:0]         addr_a,
  output logic [LOG_N-1:0]         addr_b,
  output logic [LOG_N-2:0]         tw_addr,
  output logic [$clog2(LOG_N)-1:0] stage,
  input  logic                     wb_done,
  output logic                     err
);

  localparam int SW   = $clog2(LOG_N);
  localparam int KW   = LOG_N - 1;
  localparam int IW   = pm_cnt_w(MAX_INFLIGHT);
  localparam int HALF = 1 << (LOG_N - 1);

  localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
  localparam logic [IW-1:0] I_MAX  = IW'(MAX_INFLIGHT);

  ntt_state_e       state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic             err_q, err_d;
  logic             bf_valid_q, bf_valid_d;
  logic [LOG_N-1:0] addr_a_q, addr_a_d;
  logic [LOG_N-1:0] addr_b_q, addr_b_d;
  logic [KW-1:0]    tw_q, tw_d;
  logic             issue;

  assign issue = bf_valid_q & bf_ready;

  // In-flight accounting; a write-back with nothing in flight is an error
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    case ({issue, wb_done})
      2'b10: inflight_d = inflight_q + IW'(1);
      2'b01: begin
        if (inflight_q == '0) begin
          err_d = 1'b1;
        end else begin
          inflight_d = inflight_q - IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Stage sequencing; DRAIN looks at post-update inflight
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          if (k_q == K_LAST) begin
            state_d = ST_DRAIN;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (inflight_d == '0) begin
          if (stage_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
        k_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    bf_valid_d = (state_d == ST_ISSUE) &&
                 (inflight_d != I_MAX);
  end

  ntt_addr_gen #(
    .LOG_N (LOG_N),
    .STG_W (SW)
  ) u_addr_gen (
    .k       (k_d),
    .stage   (stage_d),
    .addr_a  (addr_a_d),
    .addr_b  (addr_b_d),
    .tw_addr (tw_d)
  );

  // Scheduler state and registered command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      k_q        <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      bf_valid_q <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_q       <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      k_q        <= k_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      bf_valid_q <= bf_valid_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_q       <= tw_d;
    end
  end

  assign busy     = (state_q == ST_ISSUE) ||
                    (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign bf_valid = bf_valid_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_addr  = tw_q;
  assign stage    = stage_q;
  assign err      = err_q;

endmodule
